// File: rtl/mips_pkg.sv
// Shared definitions for the boot-time instruction loader.
//   IMEM_DEPTH     : instruction-memory depth in words (largest legal count)
//   loaderState_t  : loader FSM state encoding
//   countIllegal() : true when a parsed word count cannot be loaded
package mips_pkg;

  localparam int IMEM_DEPTH = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CNT_HI = 3'd1,
    CNT_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    DONE   = 3'd5,
    ERR    = 3'd6
  } loaderState_t;

  // An empty image or one larger than the memory is rejected.
  function automatic logic countIllegal(input logic [15:0] count, input int maxCount);
    return (count == 16'd0) || (int'(count) > maxCount);
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   in_valid/in_data/in_ready : byte stream, accepted on in_valid && in_ready
//   writeINS/WriteAddress/writeDataINS : single-cycle word write port
// slave  : loader side
// master : stream source / memory side
interface instr_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        writeINS;
  logic [29:0] WriteAddress;
  logic [31:0] writeDataINS;

  modport slave (
    input  in_valid, in_data,
    output in_ready, writeINS, WriteAddress, writeDataINS
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, writeINS, WriteAddress, writeDataINS
  );
endinterface

// File: rtl/instr_loader_word_assembler.sv
// Big-endian byte-to-word shifter.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : drop any partial word and restart at byte 0
//   byteAccept : byteIn is taken this cycle
//   byteIn     : incoming byte, MSB first
//   wordOut    : word formed by the three held bytes plus byteIn
//   wordValid  : byteAccept on the 4th byte; wordOut is complete
module word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byteAccept,
  input  logic [7:0]  byteIn,
  output logic [31:0] wordOut,
  output logic        wordValid
);
  // Only three bytes need storing: the 4th is used straight from byteIn.
  logic [23:0] shiftReg;
  logic [1:0]  byteCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (clear) begin
      shiftReg <= '0;
      byteCnt  <= '0;
    end else if (byteAccept) begin
      shiftReg <= {shiftReg[15:0], byteIn};
      byteCnt  <= byteCnt + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  assign wordOut   = {shiftReg, byteIn};
  assign wordValid = byteAccept && (byteCnt == 2'd3);

endmodule

// File: rtl/instr_loader.sv
// Boot-time program loader: parses a 16-bit big-endian word count followed
// by big-endian 32-bit words and writes each into instruction memory.
//   clk, rst : clock, asynchronous active-high reset
//   start    : begin a load (IDLE only)
//   bus      : byte stream in, instruction-memory write port out
//   cpu_hold : stalls the core while a load is in progress
//   done     : one-cycle pulse after the last write
//   err      : sticky bad-count flag, cleared by the next start
module instr_loader
  import mips_pkg::*;
#(
  parameter int MEM_DEPTH = IMEM_DEPTH,
  parameter int BASE_WORD = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  instr_loader_if.slave  bus,
  output logic           cpu_hold,
  output logic           done,
  output logic           err
);
  localparam logic [29:0] BASE_ADDR = 30'(BASE_WORD);

  loaderState_t stateReg, stateNext;
  logic [7:0]   countHiReg;
  logic [15:0]  countReg;
  logic [15:0]  indexReg;
  logic [15:0]  indexInc;
  logic [15:0]  countFull;
  logic         accept;
  logic         dataAccept;
  logic [31:0]  wordOut;
  logic         wordValid;
  logic         readyNext, writeNext, holdNext, doneNext;

  assign accept     = bus.in_valid && bus.in_ready;
  assign dataAccept = accept && (stateReg == DATA);
  assign countFull  = {countHiReg, bus.in_data};
  assign indexInc   = indexReg + 16'd1;

  // Clearing throughout CNT_LO guarantees every load starts at byte 0.
  word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (stateReg == CNT_LO),
    .byteAccept (dataAccept),
    .byteIn     (bus.in_data),
    .wordOut    (wordOut),
    .wordValid  (wordValid)
  );

  // Next state and next registered outputs.
  always_comb begin
    stateNext = stateReg;
    readyNext = 1'b0;
    writeNext = 1'b0;
    holdNext  = 1'b0;
    doneNext  = 1'b0;
    case (stateReg)
      IDLE:   if (start) stateNext = CNT_HI;
      CNT_HI: if (accept) stateNext = CNT_LO;
      CNT_LO: if (accept) stateNext = countIllegal(countFull, MEM_DEPTH) ? ERR : DATA;
      DATA:   if (wordValid) stateNext = WRITE;
      WRITE:  stateNext = (indexInc == countReg) ? DONE : DATA;
      DONE:   stateNext = IDLE;
      ERR:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    // Outputs are registered, so they are decoded from the state being entered.
    readyNext = (stateNext == CNT_HI) || (stateNext == CNT_LO) || (stateNext == DATA);
    holdNext  = readyNext || (stateNext == WRITE);
    writeNext = (stateNext == WRITE);
    doneNext  = (stateNext == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg         <= IDLE;
      countHiReg       <= '0;
      countReg         <= '0;
      indexReg         <= '0;
      bus.in_ready     <= 1'b0;
      bus.writeINS     <= 1'b0;
      bus.WriteAddress <= '0;
      bus.writeDataINS <= '0;
      cpu_hold         <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      bus.in_ready <= readyNext;
      bus.writeINS <= writeNext;
      cpu_hold     <= holdNext;
      done         <= doneNext;

      if (stateReg == CNT_HI && accept) countHiReg <= bus.in_data;
      if (stateReg == CNT_LO && accept) begin
        countReg <= countFull;
        indexReg <= '0;
      end
      if (stateReg == WRITE) indexReg <= indexInc;

      // Address/data load only on entry to WRITE, so they hold otherwise.
      if (wordValid) begin
        bus.writeDataINS <= wordOut;
        bus.WriteAddress <= BASE_ADDR + {14'd0, indexReg};
      end

      if (stateReg == IDLE && start) err <= 1'b0;
      else if (stateNext == ERR)     err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic inValid = 1'b0;
  logic [7:0] inData = 8'h00;
  logic hold0, done0, err0, hold1, done1, err1;
  bit   curSel = 1'b0;

  int tests = 0;
  int fails = 0;

  instr_loader_if bus0 ();
  instr_loader_if bus1 ();

  assign bus0.in_valid = inValid;
  assign bus0.in_data  = inData;
  assign bus1.in_valid = inValid;
  assign bus1.in_data  = inData;

  instr_loader #(.MEM_DEPTH(IMEM_DEPTH), .BASE_WORD(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0),
    .cpu_hold(hold0), .done(done0), .err(err0)
  );

  instr_loader #(.MEM_DEPTH(IMEM_DEPTH), .BASE_WORD(16)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .cpu_hold(hold1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  logic curReady, curHold, curDone, curErr;
  assign curReady = curSel ? bus1.in_ready : bus0.in_ready;
  assign curHold  = curSel ? hold1 : hold0;
  assign curDone  = curSel ? done1 : done0;
  assign curErr   = curSel ? err1  : err0;

  // Write/done monitor, sampled on the falling edge.
  logic [29:0] logA[$];
  logic [31:0] logD[$];
  int doneTotal = 0;
  int overlap   = 0;

  always @(negedge clk) begin
    if (bus0.writeINS) begin logA.push_back(bus0.WriteAddress); logD.push_back(bus0.writeDataINS); end
    if (bus1.writeINS) begin logA.push_back(bus1.WriteAddress); logD.push_back(bus1.writeDataINS); end
    if (done0) doneTotal++;
    if (done1) doneTotal++;
    if ((bus0.writeINS && bus0.in_ready) || (bus1.writeINS && bus1.in_ready)) overlap++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] patWord(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b ^ 8'h5A, 8'hC3, ~b, b + 8'h11};
  endfunction

  typedef struct {
    int          sel;
    logic [15:0] count;
    int          nSend;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          pattern;
    int          gapMax;
    int          midStart;
    bit          expErr;
  } vec_t;

  vec_t vecs[9];
  int holdDrops;

  function automatic logic [31:0] vecWord(input vec_t v, input int k);
    if (v.pattern) return patWord(k);
    return (k == 0) ? v.w0 : v.w1;
  endfunction

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    inValid = 1'b0;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      inValid = 1'b0;
      if (!curHold) holdDrops++;
    end
    @(negedge clk);
    inValid = 1'b1;
    inData  = b;
    t = 0;
    while (!curReady && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!curHold) holdDrops++;
    chk("ready_wait", 64'(t >= 40), 64'd0);
    @(posedge clk);
  endtask

  function automatic logic [7:0] vecByte(input vec_t v, input int b);
    logic [31:0] w;
    if (b == 0) return v.count[15:8];
    if (b == 1) return v.count[7:0];
    w = vecWord(v, (b - 2) / 4);
    return 8'(w >> (8 * (3 - ((b - 2) % 4))));
  endfunction

  task automatic do_load(input int idx, input vec_t v);
    int logBase, doneBase, nBytes, t, expWrites, base;
    curSel    = (v.sel != 0);
    logBase   = logA.size();
    doneBase  = doneTotal;
    holdDrops = 0;
    base      = v.sel != 0 ? 16 : 0;
    expWrites = v.expErr ? 0 : int'(v.count);

    pulse_start(curSel);
    chk("err_cleared_by_start", 64'(curErr), 64'd0);
    chk("hold_after_start", 64'(curHold), 64'd1);

    nBytes = 2 + 4 * v.nSend;
    for (int b = 0; b < nBytes; b++) begin
      send_byte(vecByte(v, b), (v.gapMax > 0) ? int'($urandom_range(v.gapMax, 0)) : 0);
      if (b == v.midStart) pulse_start(curSel);
    end
    @(negedge clk);
    inValid = 1'b0;

    t = 0;
    while (!(curDone || curErr) && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("finish_wait", 64'(t >= 20), 64'd0);
    repeat (2) @(negedge clk);

    chk("hold_dropped_mid_load", 64'(holdDrops), 64'd0);
    chk("hold_final", 64'(curHold), 64'd0);
    chk("err_final", 64'(curErr), 64'(v.expErr));
    chk("done_pulses", 64'(doneTotal - doneBase), v.expErr ? 64'd0 : 64'd1);
    chk("write_count", 64'(logA.size() - logBase), 64'(expWrites));
    for (int k = 0; k < expWrites && (logBase + k) < logA.size(); k++) begin
      chk("write_addr", 64'(logA[logBase + k]), 64'(base + k));
      chk("write_data", 64'(logD[logBase + k]), 64'(vecWord(v, k)));
    end
    $display("[TB] vec %0d: dut%0d count=%0h gaps<=%0d writes=%0d err=%0b",
             idx, v.sel, v.count, v.gapMax, logA.size() - logBase, curErr);
  endtask

  initial begin
    vecs[0] = '{0, 16'h0002,   2, 32'h8C080000, 32'h21090005, 1'b0, 0, -1, 1'b0};
    vecs[1] = '{1, 16'h0001,   1, 32'h03E00008, 32'h00000000, 1'b0, 0, -1, 1'b0};
    vecs[2] = '{0, 16'h0081,   0, 32'h00000000, 32'h00000000, 1'b0, 0, -1, 1'b1};
    vecs[3] = '{0, 16'h0000,   0, 32'h00000000, 32'h00000000, 1'b0, 0, -1, 1'b1};
    vecs[4] = '{0, 16'h0080, 128, 32'h00000000, 32'h00000000, 1'b1, 0, -1, 1'b0};
    vecs[5] = '{0, 16'h0020,  32, 32'h00000000, 32'h00000000, 1'b1, 0, -1, 1'b0};
    vecs[6] = '{0, 16'h0020,  32, 32'h00000000, 32'h00000000, 1'b1, 5, -1, 1'b0};
    vecs[7] = '{0, 16'hFFFF,   0, 32'h00000000, 32'h00000000, 1'b0, 0, -1, 1'b1};
    vecs[8] = '{0, 16'h0002,   2, 32'hDEADBEEF, 32'h01234567, 1'b0, 0,  4, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(bus0.in_ready), 64'd0);
    chk("rst_writeINS", 64'(bus0.writeINS), 64'd0);
    chk("rst_WriteAddress", 64'(bus0.WriteAddress), 64'd0);
    chk("rst_writeDataINS", 64'(bus0.writeDataINS), 64'd0);
    chk("rst_hold_done_err", 64'({hold0, done0, err0}), 64'd0);
    rst = 1'b0;
    $display("[TB] reset released");

    for (int i = 0; i < 9; i++) do_load(i, vecs[i]);

    // Reset after the 2nd byte of word 3 in a 5-word load.
    begin
      vec_t v;
      int logBase, doneBase;
      v = '{0, 16'h0005, 5, 32'h0, 32'h0, 1'b1, 0, -1, 1'b0};
      curSel   = 1'b0;
      logBase  = logA.size();
      doneBase = doneTotal;
      pulse_start(1'b0);
      for (int b = 0; b < 2 + 4 * 3 + 2; b++) send_byte(vecByte(v, b), 0);
      #2 rst = 1'b1;
      #1;
      chk("abort_in_ready", 64'(bus0.in_ready), 64'd0);
      chk("abort_writeINS", 64'(bus0.writeINS), 64'd0);
      chk("abort_WriteAddress", 64'(bus0.WriteAddress), 64'd0);
      chk("abort_writeDataINS", 64'(bus0.writeDataINS), 64'd0);
      chk("abort_hold_done_err", 64'({hold0, done0, err0}), 64'd0);
      inValid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("abort_write_count", 64'(logA.size() - logBase), 64'd3);
      for (int k = 0; k < 3 && (logBase + k) < logA.size(); k++) begin
        chk("abort_write_addr", 64'(logA[logBase + k]), 64'(k));
        chk("abort_write_data", 64'(logD[logBase + k]), 64'(patWord(k)));
      end
      chk("abort_no_done", 64'(doneTotal - doneBase), 64'd0);
      $display("[TB] reset-abort load: writes=%0d", logA.size() - logBase);
    end

    chk("ready_during_write", 64'(overlap), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
